// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared MIPS encodings (opcode_t, funct_t, aluop_t) plus the types and select
// constants used by the multicycle control unit: mcu_state_t, the instruction
// class produced by mcu_decode, the decode_t bundle and the PCsrc / ALUsrc /
// RegDst mux encodings.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ADDIU = 6'h09,
        SLTI  = 6'h0A,
        SLTIU = 6'h0B,
        ANDI  = 6'h0C,
        ORI   = 6'h0D,
        XORI  = 6'h0E,
        LUI   = 6'h0F,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'h00,
        SRL  = 6'h02,
        JR   = 6'h08,
        ADD  = 6'h20,
        ADDU = 6'h21,
        SUB  = 6'h22,
        SUBU = 6'h23,
        AND  = 6'h24,
        OR   = 6'h25,
        XOR  = 6'h26,
        NOR  = 6'h27,
        SLT  = 6'h2A,
        SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5,
        EXC    = 3'd6
    } mcu_state_t;

    // Coarse instruction class: tells the FSM which path through the states to take.
    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_LUI,
        CLS_HALT
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        aluop_t     aluop;
        logic [1:0] alusrc;
        logic [1:0] regdst;
        logic       memtoreg;
        logic       illegal;
    } decode_t;

    localparam logic [2:0] PCSRC_PC4 = 3'd0;
    localparam logic [2:0] PCSRC_JR  = 3'd2;
    localparam logic [2:0] PCSRC_J   = 3'd3;
    localparam logic [2:0] PCSRC_BNE = 3'd4;
    localparam logic [2:0] PCSRC_BEQ = 3'd5;
    localparam logic [2:0] PCSRC_VEC = 3'd6;

    localparam logic [1:0] ALUSRC_RT    = 2'd0;
    localparam logic [1:0] ALUSRC_SHAMT = 2'd1;
    localparam logic [1:0] ALUSRC_SIMM  = 2'd2;
    localparam logic [1:0] ALUSRC_ZIMM  = 2'd3;

    localparam logic [1:0] REGDST_RD = 2'd0;
    localparam logic [1:0] REGDST_RT = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

endpackage

// File: rtl/mcu_decode.sv
// -----------------------------------------------------------------------------
// mcu_decode
// Purely combinational instruction decoder. Maps opcode/funct to an
// instruction class plus the ALU operation, ALU operand select, destination
// register select and memory write-back flag. Encodings match the original
// single-cycle decoder.
//   opcode  in  6   IR[31:26]
//   funct   in  6   IR[5:0]
//   dec     out     decode_t bundle {cls, aluop, alusrc, regdst, memtoreg, illegal}
// -----------------------------------------------------------------------------
module mcu_decode
    import cpu_types_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        dec.cls      = CLS_NOP;
        dec.aluop    = ALU_SLL;
        dec.alusrc   = ALUSRC_RT;
        dec.regdst   = REGDST_RT;
        dec.memtoreg = 1'b0;
        dec.illegal  = 1'b0;

        case (opcode_t'(opcode))
            RTYPE: begin
                dec.cls    = CLS_ALU;
                dec.regdst = REGDST_RD;
                case (funct_t'(funct))
                    SLL:       begin dec.aluop = ALU_SLL; dec.alusrc = ALUSRC_SHAMT; end
                    SRL:       begin dec.aluop = ALU_SRL; dec.alusrc = ALUSRC_SHAMT; end
                    JR:        dec.cls   = CLS_JR;
                    ADD, ADDU: dec.aluop = ALU_ADD;
                    SUB, SUBU: dec.aluop = ALU_SUB;
                    AND:       dec.aluop = ALU_AND;
                    OR:        dec.aluop = ALU_OR;
                    XOR:       dec.aluop = ALU_XOR;
                    NOR:       dec.aluop = ALU_NOR;
                    SLT:       dec.aluop = ALU_SLT;
                    SLTU:      dec.aluop = ALU_SLTU;
                    default: begin
                        dec.cls     = CLS_NOP;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            ADDI, ADDIU: begin dec.cls = CLS_ALU; dec.aluop = ALU_ADD;  dec.alusrc = ALUSRC_SIMM; end
            SLTI:        begin dec.cls = CLS_ALU; dec.aluop = ALU_SLT;  dec.alusrc = ALUSRC_SIMM; end
            SLTIU:       begin dec.cls = CLS_ALU; dec.aluop = ALU_SLTU; dec.alusrc = ALUSRC_SIMM; end
            ANDI:        begin dec.cls = CLS_ALU; dec.aluop = ALU_AND;  dec.alusrc = ALUSRC_ZIMM; end
            ORI:         begin dec.cls = CLS_ALU; dec.aluop = ALU_OR;   dec.alusrc = ALUSRC_ZIMM; end
            XORI:        begin dec.cls = CLS_ALU; dec.aluop = ALU_XOR;  dec.alusrc = ALUSRC_ZIMM; end
            LUI:         dec.cls = CLS_LUI;
            LW: begin
                dec.cls      = CLS_LW;
                dec.aluop    = ALU_ADD;
                dec.alusrc   = ALUSRC_SIMM;
                dec.memtoreg = 1'b1;
            end
            SW:   begin dec.cls = CLS_SW;  dec.aluop = ALU_ADD; dec.alusrc = ALUSRC_SIMM; end
            BEQ:  begin dec.cls = CLS_BEQ; dec.aluop = ALU_SUB; end
            BNE:  begin dec.cls = CLS_BNE; dec.aluop = ALU_SUB; end
            J:    dec.cls = CLS_J;
            JAL:  dec.cls = CLS_JAL;
            HALT: dec.cls = CLS_HALT;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Multicycle MIPS control: latches each instruction into IR and sequences
// FETCH/DECODE/EXEC/MEM/WB, holding iREN/dREN/dWEN until ihit/dhit. A watchdog
// halts the core (bus_err, halt) when a memory handshake stalls for
// TIMEOUT_CYC cycles; TIMEOUT_CYC = 0 disables it.
//
// Build option: define MCU_EXCEPTION_EN to trap unknown encodings into the EXC
// state (PC <- exception vector) and expose exc / exc_cause. Without it,
// unknown encodings execute as NOPs.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-high reset
//   imemload, ihit, dhit     instruction word and cache handshakes
//   zero                     ALU zero flag, sampled in EXEC
//   iREN, dREN, dWEN         memory request strobes
//   PCWrite, PCsrc           PC load enable and PC mux select
//   aluop, ALUsrc            ALU operation and operand-B select
//   RegDst, RegWrite         register file destination select / write enable
//   MemtoReg, lui            write-back source selects
//   rs, rt, rd, shamt, imm, addr   IR fields
//   halt, bus_err            sticky halt and watchdog-expiry flags
//   exc, exc_cause           exception pulse and cause (MCU_EXCEPTION_EN only)
//   state                    current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] imemload,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        zero,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        PCWrite,
    output logic [2:0]  PCsrc,
    output aluop_t      aluop,
    output logic [1:0]  ALUsrc,
    output logic [1:0]  RegDst,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        lui,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm,
    output logic [25:0] addr,
    output logic        halt,
    output logic        bus_err,
`ifdef MCU_EXCEPTION_EN
    output logic        exc,
    output logic [5:0]  exc_cause,
`endif
    output mcu_state_t  state
);

    localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    mcu_state_t       cur_state, next_state;
    logic [31:0]      ir;
    logic [TMR_W-1:0] timer, timer_next;
    logic             ir_load;
    logic             waiting;   // state is blocked on a memory handshake
    logic             hit;       // the handshake this state waits on
    logic             expire;
    decode_t          dec;

    mcu_decode u_decode (
        .opcode (ir[31:26]),
        .funct  (ir[5:0]),
        .dec    (dec)
    );

    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign imm   = ir[15:0];
    assign addr  = ir[25:0];
    assign halt  = (cur_state == HALTED);
    assign state = cur_state;

    always_comb begin
        next_state = cur_state;
        iREN       = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        PCWrite    = 1'b0;
        PCsrc      = PCSRC_PC4;
        aluop      = ALU_SLL;
        ALUsrc     = ALUSRC_RT;
        RegDst     = REGDST_RD;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        lui        = 1'b0;
        ir_load    = 1'b0;
        waiting    = 1'b0;
        hit        = 1'b0;
`ifdef MCU_EXCEPTION_EN
        exc        = 1'b0;
`endif

        case (cur_state)
            FETCH: begin
                iREN    = 1'b1;
                waiting = 1'b1;
                hit     = ihit;
                if (ihit) begin
                    ir_load    = 1'b1;
                    PCWrite    = 1'b1;
                    PCsrc      = PCSRC_PC4;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (dec.illegal) begin
`ifdef MCU_EXCEPTION_EN
                    next_state = EXC;
`else
                    next_state = FETCH;
`endif
                end else begin
                    case (dec.cls)
                        CLS_HALT: next_state = HALTED;
                        CLS_J: begin
                            PCWrite    = 1'b1;
                            PCsrc      = PCSRC_J;
                            next_state = FETCH;
                        end
                        CLS_JAL: begin
                            PCWrite    = 1'b1;
                            PCsrc      = PCSRC_J;
                            RegWrite   = 1'b1;
                            RegDst     = REGDST_RA;
                            next_state = FETCH;
                        end
                        CLS_JR: begin
                            PCWrite    = 1'b1;
                            PCsrc      = PCSRC_JR;
                            next_state = FETCH;
                        end
                        CLS_LUI: begin
                            RegWrite   = 1'b1;
                            lui        = 1'b1;
                            RegDst     = REGDST_RT;
                            next_state = FETCH;
                        end
                        CLS_NOP: next_state = FETCH;
                        default: next_state = EXEC;
                    endcase
                end
            end
            EXEC: begin
                aluop  = dec.aluop;
                ALUsrc = dec.alusrc;
                case (dec.cls)
                    CLS_BEQ: begin
                        PCWrite    = zero;
                        PCsrc      = PCSRC_BEQ;
                        next_state = FETCH;
                    end
                    CLS_BNE: begin
                        PCWrite    = ~zero;
                        PCsrc      = PCSRC_BNE;
                        next_state = FETCH;
                    end
                    CLS_LW, CLS_SW: next_state = MEM;
                    default:        next_state = WB;
                endcase
            end
            MEM: begin
                // Address must stay stable for the whole handshake.
                aluop   = ALU_ADD;
                ALUsrc  = ALUSRC_SIMM;
                waiting = 1'b1;
                hit     = dhit;
                if (dec.cls == CLS_LW) dREN = 1'b1;
                else                   dWEN = 1'b1;
                if (dhit) next_state = (dec.cls == CLS_LW) ? WB : FETCH;
            end
            WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = dec.memtoreg;
                RegDst     = dec.regdst;
                next_state = FETCH;
            end
            HALTED: next_state = HALTED;
`ifdef MCU_EXCEPTION_EN
            EXC: begin
                exc        = 1'b1;
                PCWrite    = 1'b1;
                PCsrc      = PCSRC_VEC;
                next_state = FETCH;
            end
`endif
            default: next_state = FETCH;
        endcase

        // A hit on the expiry cycle takes priority, so expiry requires !hit.
        expire = (TIMEOUT_CYC != 0) && waiting && !hit && (timer == TMR_LAST);
        if (expire) next_state = HALTED;

        if ((TIMEOUT_CYC != 0) && waiting && !hit && (next_state == cur_state))
            timer_next = timer + TMR_W'(1);
        else
            timer_next = '0;

        // Reset forces every strobe low right away, even mid-handshake.
        if (RST) begin
            iREN     = 1'b0;
            dREN     = 1'b0;
            dWEN     = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemtoReg = 1'b0;
            lui      = 1'b0;
            ir_load  = 1'b0;
`ifdef MCU_EXCEPTION_EN
            exc      = 1'b0;
`endif
        end
    end

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_state <= FETCH;
            // NOTE: IR is reset like any other flop; the field outputs must read 0 during reset.
            ir        <= '0;
            timer     <= '0;
            bus_err   <= 1'b0;
        end else begin
            cur_state <= next_state;
            timer     <= timer_next;
            if (ir_load) ir      <= imemload;
            if (expire)  bus_err <= 1'b1;
        end
    end

`ifdef MCU_EXCEPTION_EN
    // Cause is captured on entry to EXC so it is already valid during the exc pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exc_cause <= '0;
        end else if (cur_state == DECODE && next_state == EXC) begin
            exc_cause <= (ir[31:26] == RTYPE) ? ir[5:0] : ir[31:26];
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Scoreboard bench for multicycle_control_unit (TIMEOUT_CYC = 8). Each stimulus
// cycle pushes the hand-derived expected output vector; a negedge monitor pops
// and compares it. Exercises ALU R/I types, LW/SW handshakes, branches, jumps,
// LUI, unknown encodings, reset mid-MEM, watchdog expiry / hit-on-last-cycle
// and HALT. Honours MCU_EXCEPTION_EN if defined.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;
    import cpu_types_pkg::*;

    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] imemload;
    logic        ihit, dhit, zero;
    logic        iREN, dREN, dWEN, PCWrite, RegWrite, MemtoReg, lui, halt, bus_err;
    logic [2:0]  PCsrc;
    aluop_t      aluop;
    logic [1:0]  ALUsrc, RegDst;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] addr;
    mcu_state_t  state;
    logic        exc_w;
`ifdef MCU_EXCEPTION_EN
    logic [5:0]  exc_cause_w;
`endif

    always #5 CLK = ~CLK;

    multicycle_control_unit #(.TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST), .imemload(imemload), .ihit(ihit), .dhit(dhit), .zero(zero),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .PCWrite(PCWrite), .PCsrc(PCsrc),
        .aluop(aluop), .ALUsrc(ALUsrc), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .lui(lui), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .addr(addr), .halt(halt), .bus_err(bus_err),
`ifdef MCU_EXCEPTION_EN
        .exc(exc_w), .exc_cause(exc_cause_w),
`endif
        .state(state)
    );
`ifndef MCU_EXCEPTION_EN
    assign exc_w = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       iren, dren, dwen, pcw;
        logic [2:0] pcsrc;
        logic [3:0] aluop;
        logic [1:0] alusrc, regdst;
        logic       regw, m2r, lui, halt, berr, exc;
    } obs_t;

    typedef struct {
        string       tag;
        obs_t        o;
        logic        fchk;
        logic [25:0] f;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t s;
        s.st = state;   s.iren = iREN;  s.dren = dREN;   s.dwen = dWEN;
        s.pcw = PCWrite; s.pcsrc = PCsrc; s.aluop = aluop; s.alusrc = ALUsrc;
        s.regdst = RegDst; s.regw = RegWrite; s.m2r = MemtoReg; s.lui = lui;
        s.halt = halt;  s.berr = bus_err; s.exc = exc_w;
        return s;
    endfunction

    function automatic obs_t idle(input mcu_state_t s);
        obs_t o;
        o = '0;
        o.st = s;
        return o;
    endfunction

    // Monitor: compare every pending expectation at the negedge.
    always @(negedge CLK) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check(mon_e.tag, 32'(sample()), 32'(mon_e.o));
            if (mon_e.fchk) begin
                check({mon_e.tag, "_addr"}, 32'(addr), 32'(mon_e.f));
                check({mon_e.tag, "_rs_rt_imm"}, 32'({rs, rt, imm}), 32'(mon_e.f));
                check({mon_e.tag, "_rd_shamt"}, 32'({rs, rt, rd, shamt, imm[5:0]}), 32'(mon_e.f));
            end
        end
    end

    // Drives one cycle of inputs (just after a posedge) and queues the expectation.
    task automatic step(input string tag, input logic ih, input logic dh, input logic z,
                        input obs_t o, input logic fchk = 1'b0);
        exp_t e;
        ihit = ih; dhit = dh; zero = z;
        e.tag = tag; e.o = o; e.fchk = fchk; e.f = cur_instr[25:0];
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        cur_instr = '0;
        step({tag, "_rst0"}, 1'b1, 1'b1, 1'b0, idle(FETCH), 1'b1);
        step({tag, "_rst1"}, 1'b1, 1'b1, 1'b0, idle(FETCH), 1'b1);
        RST = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] instr, input int waits);
        obs_t o;
        imemload = instr;
        o = idle(FETCH);
        o.iren = 1'b1;
        for (int i = 0; i < waits; i++) step({tag, "_fwait"}, 1'b0, 1'b0, 1'b0, o);
        o.pcw   = 1'b1;
        o.pcsrc = PCSRC_PC4;
        step({tag, "_fhit"}, 1'b1, 1'b0, 1'b0, o);
        cur_instr = instr;
    endtask

    // ALU-class instruction: DECODE, EXEC with the given ALU controls, WB.
    task automatic alu_instr(input string tag, input logic [31:0] instr, input aluop_t op,
                             input logic [1:0] src, input logic [1:0] dst);
        obs_t o;
        fetch(tag, instr, 1);
        step({tag, "_dec"}, 1'b0, 1'b0, 1'b0, idle(DECODE), 1'b1);
        o = idle(EXEC); o.aluop = op; o.alusrc = src;
        step({tag, "_exec"}, 1'b0, 1'b0, 1'b0, o);
        o = idle(WB); o.regw = 1'b1; o.regdst = dst;
        step({tag, "_wb"}, 1'b0, 1'b0, 1'b0, o);
    endtask

    task automatic branch(input string tag, input logic [31:0] instr, input logic z,
                          input logic [2:0] sel, input logic taken);
        obs_t o;
        fetch(tag, instr, 0);
        step({tag, "_dec"}, 1'b0, 1'b0, 1'b0, idle(DECODE), 1'b1);
        o = idle(EXEC); o.aluop = ALU_SUB; o.alusrc = ALUSRC_RT; o.pcw = taken; o.pcsrc = sel;
        step({tag, "_exec"}, 1'b0, 1'b0, z, o);
    endtask

    // Instruction completing in DECODE with the given strobes.
    task automatic dec_only(input string tag, input logic [31:0] instr, input obs_t o);
        fetch(tag, instr, 0);
        step({tag, "_dec"}, 1'b0, 1'b0, 1'b0, o, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        obs_t o;
        RST = 1'b1; imemload = '0; ihit = 1'b0; dhit = 1'b0; zero = 1'b0; cur_instr = '0;
        @(posedge CLK);
        #1;
        do_reset("init");

        // ADDIU $1,$0,5 with two wait cycles; FETCH re-entered on cycle 7.
        imemload = 32'h24010005;
        o = idle(FETCH); o.iren = 1'b1;
        step("addiu_fwait0", 1'b0, 1'b0, 1'b0, o);
        step("addiu_fwait1", 1'b0, 1'b0, 1'b0, o);
        o.pcw = 1'b1;
        step("addiu_fhit", 1'b1, 1'b0, 1'b0, o);
        cur_instr = 32'h24010005;
        step("addiu_dec", 1'b0, 1'b0, 1'b0, idle(DECODE), 1'b1);
        o = idle(EXEC); o.aluop = ALU_ADD; o.alusrc = ALUSRC_SIMM;
        step("addiu_exec", 1'b0, 1'b0, 1'b0, o);
        o = idle(WB); o.regw = 1'b1; o.regdst = REGDST_RT;
        step("addiu_wb", 1'b0, 1'b0, 1'b0, o);
        o = idle(FETCH); o.iren = 1'b1;
        step("addiu_refetch", 1'b0, 1'b0, 1'b0, o);

        // LW $2,4($1) with dhit delayed 4 cycles.
        fetch("lw", 32'h8C220004, 0);
        step("lw_dec", 1'b0, 1'b0, 1'b0, idle(DECODE), 1'b1);
        o = idle(EXEC); o.aluop = ALU_ADD; o.alusrc = ALUSRC_SIMM;
        step("lw_exec", 1'b0, 1'b0, 1'b0, o);
        o = idle(MEM); o.dren = 1'b1; o.aluop = ALU_ADD; o.alusrc = ALUSRC_SIMM;
        for (int i = 0; i < 4; i++) step("lw_mem_wait", 1'b0, 1'b0, 1'b0, o);
        step("lw_mem_hit", 1'b0, 1'b1, 1'b0, o);
        o = idle(WB); o.regw = 1'b1; o.m2r = 1'b1; o.regdst = REGDST_RT;
        step("lw_wb", 1'b0, 1'b0, 1'b0, o);

        // Branches.
        branch("beq_taken",    32'h10220003, 1'b1, PCSRC_BEQ, 1'b1);
        branch("beq_nottaken", 32'h10220003, 1'b0, PCSRC_BEQ, 1'b0);
        branch("bne_taken",    32'h14220003, 1'b0, PCSRC_BNE, 1'b1);
        branch("bne_nottaken", 32'h14220003, 1'b1, PCSRC_BNE, 1'b0);

        // ALU R/I types.
        alu_instr("addu", 32'h00221821, ALU_ADD, ALUSRC_RT,    REGDST_RD);
        alu_instr("ori",  32'h34220F0F, ALU_OR,  ALUSRC_ZIMM,  REGDST_RT);
        alu_instr("sll",  32'h00021900, ALU_SLL, ALUSRC_SHAMT, REGDST_RD);
        alu_instr("slt",  32'h0022182A, ALU_SLT, ALUSRC_RT,    REGDST_RD);
        alu_instr("slti", 32'h2822FFFF, ALU_SLT, ALUSRC_SIMM,  REGDST_RT);

        // Jumps and LUI complete in DECODE.
        o = idle(DECODE); o.pcw = 1'b1; o.pcsrc = PCSRC_J;
        dec_only("j", 32'h08000010, o);
        o.regw = 1'b1; o.regdst = REGDST_RA;
        dec_only("jal", 32'h0C000010, o);
        o = idle(DECODE); o.pcw = 1'b1; o.pcsrc = PCSRC_JR;
        dec_only("jr", 32'h03E00008, o);
        o = idle(DECODE); o.regw = 1'b1; o.lui = 1'b1; o.regdst = REGDST_RT;
        dec_only("lui", 32'h3C011234, o);

        // Unknown opcode 0x3E and unknown funct 0x3F.
        dec_only("bad_op", 32'hF8000000, idle(DECODE));
`ifdef MCU_EXCEPTION_EN
        o = idle(EXC); o.exc = 1'b1; o.pcw = 1'b1; o.pcsrc = PCSRC_VEC;
        step("bad_op_exc", 1'b0, 1'b0, 1'b0, o);
        check("exc_cause_op", 32'(exc_cause_w), 32'h3E);
`endif
        dec_only("bad_funct", 32'h0000003F, idle(DECODE));
`ifdef MCU_EXCEPTION_EN
        o = idle(EXC); o.exc = 1'b1; o.pcw = 1'b1; o.pcsrc = PCSRC_VEC;
        step("bad_funct_exc", 1'b0, 1'b0, 1'b0, o);
        check("exc_cause_funct", 32'(exc_cause_w), 32'h3F);
`endif

        // SW completing normally after one wait cycle.
        fetch("sw", 32'hAC220008, 0);
        step("sw_dec", 1'b0, 1'b0, 1'b0, idle(DECODE), 1'b1);
        o = idle(EXEC); o.aluop = ALU_ADD; o.alusrc = ALUSRC_SIMM;
        step("sw_exec", 1'b0, 1'b0, 1'b0, o);
        o = idle(MEM); o.dwen = 1'b1; o.aluop = ALU_ADD; o.alusrc = ALUSRC_SIMM;
        step("sw_mem_wait", 1'b0, 1'b0, 1'b0, o);
        step("sw_mem_hit", 1'b0, 1'b1, 1'b0, o);

        // SW interrupted by reset while waiting in MEM.
        fetch("sw_rst", 32'hAC220008, 0);
        step("sw_rst_dec", 1'b0, 1'b0, 1'b0, idle(DECODE), 1'b1);
        o = idle(EXEC); o.aluop = ALU_ADD; o.alusrc = ALUSRC_SIMM;
        step("sw_rst_exec", 1'b0, 1'b0, 1'b0, o);
        o = idle(MEM); o.dwen = 1'b1; o.aluop = ALU_ADD; o.alusrc = ALUSRC_SIMM;
        step("sw_rst_mem0", 1'b0, 1'b0, 1'b0, o);
        step("sw_rst_mem1", 1'b0, 1'b0, 1'b0, o);
        do_reset("sw_mid_mem");

        // Watchdog: no ihit for TO FETCH cycles -> HALTED with bus_err, sticky.
        o = idle(FETCH); o.iren = 1'b1;
        for (int i = 0; i < TO; i++) step("wd_fetch_wait", 1'b0, 1'b0, 1'b0, o);
        o = idle(HALTED); o.halt = 1'b1; o.berr = 1'b1;
        for (int i = 0; i < 4; i++) step("wd_halted", 1'b1, 1'b1, 1'b0, o);
        do_reset("wd");

        // Watchdog: ihit on the last allowed cycle wins.
        o = idle(DECODE); o.regw = 1'b1; o.lui = 1'b1; o.regdst = REGDST_RT;
        fetch("wd_hit_last", 32'h3C01ABCD, TO - 1);
        step("wd_hit_last_dec", 1'b0, 1'b0, 1'b0, o, 1'b1);

        // HALT: absorbing for 20 cycles regardless of handshakes.
        dec_only("halt", 32'hFC000000, idle(DECODE));
        o = idle(HALTED); o.halt = 1'b1;
        for (int i = 0; i < 20; i++)
            step("halt_hold", 1'(i % 2), 1'(i % 3 == 0), 1'(i % 5 == 0), o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multicycle successor to the single-cycle MIPS decoder. It latches each instruction into an internal IR and sequences FETCH/DECODE/EXEC/MEM/WB over several cycles, holding memory requests until ihit/dhit arrive. A parametrised watchdog halts the core on a stalled memory handshake. It sits between the caches/memory controller and the multicycle datapath (PC, regfile, ALU, muxes).

Parameters:
TIMEOUT_CYC, 256, max cycles to wait for ihit/dhit; 0 disables the watchdog
TMR_W, $clog2(TIMEOUT_CYC+1), watchdog counter width (derived; minimum 1)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
imemload  in  32  instruction word from instruction memory
ihit  in  1  instruction read complete
dhit  in  1  data read/write complete
zero  in  1  ALU zero flag (valid in EXEC)
iREN  out  1  instruction read request
dREN  out  1  data read request
dWEN  out  1  data write request
PCWrite  out  1  PC register load enable
PCsrc  out  3  PC mux select: 0=PC+4, 2=JR, 3=jump, 4=BNE, 5=BEQ, 6=exception vector
aluop  out  4  aluop_t
ALUsrc  out  2  0=rt, 1=shamt, 2=sign-extended imm, 3=zero-extended imm
RegDst  out  2  0=rd, 1=rt, 2=$31
RegWrite  out  1  register file write enable
MemtoReg  out  1  write-back from memory
lui  out  1  write-back imm<<16
rs, rt, rd  out  5 each  register fields from IR
shamt  out  5  IR[10:6]
imm  out  16  IR[15:0]
addr  out  26  IR[25:0]
halt  out  1  sticky halt
bus_err  out  1  sticky watchdog expiry
state  out  3  mcu_state_t (debug)

Behaviour:
- Reset (async): state=FETCH, IR=0, timer=0, halt=0, bus_err=0. All strobes are 0 while RST is high. Field outputs track IR, so they are 0 during reset.
- Strobes and selects are combinational from state, IR, and the hit/zero inputs. They default to 0 in every state. Field outputs are always driven from IR.
- FETCH: iREN=1. On ihit: load IR from imemload, PCWrite=1, PCsrc=0, go to DECODE. Otherwise stay.
- DECODE: decode IR. Field and ALU encodings are identical to the existing single-cycle decoder.
  - HALT: go to HALTED.
  - J: PCWrite=1, PCsrc=3, go to FETCH.
  - JAL: PCWrite=1, PCsrc=3, RegWrite=1, RegDst=2, go to FETCH.
  - JR: PCWrite=1, PCsrc=2, go to FETCH.
  - Unknown opcode or funct: NOP, go to FETCH.
  - LUI: RegWrite=1, lui=1, RegDst=1, go to FETCH.
  - All others: go to EXEC.
- EXEC: drive aluop and ALUsrc.
  - BEQ/BNE: aluop=SUB; PCWrite=zero (BEQ) or !zero (BNE); PCsrc=5 or 4; go to FETCH.
  - LW/SW: go to MEM.
  - ALU R/I types: go to WB.
- MEM: aluop=ADD and ALUsrc=2 are held throughout. LW holds dREN=1; SW holds dWEN=1. On dhit: LW goes to WB, SW goes to FETCH.
- WB: RegWrite=1 for exactly one cycle; MemtoReg=1 for LW; RegDst=0 for R-type, 1 for I-type; go to FETCH.
- HALTED: halt=1, absorbing until RST; no strobes asserted.
- Watchdog:
  - Timer clears on every state change. It increments each cycle in FETCH without ihit and in MEM without dhit.
  - When timer reaches TIMEOUT_CYC-1 without a hit: set bus_err=1 and go to HALTED.
  - A hit in the same cycle as expiry wins: no error.
  - TIMEOUT_CYC=0 disables the watchdog; the timer is held at 0.
- Reset mid-MEM drops dREN/dWEN immediately (asynchronous). After deassertion, the next request is an instruction fetch.

Optional Feature:
MCU_EXCEPTION_EN
- Defined: an unknown opcode or funct in DECODE enters state EXC for one cycle.
  - EXC drives PCWrite=1, PCsrc=6 and sets sticky output exc_cause[5:0] to the offending opcode (or funct for R-type), then goes to FETCH.
  - Ports exc (1-cycle pulse in EXC) and exc_cause are present.
- Undefined: unknown encodings are NOPs; the EXC state and those ports do not exist.

Decomposition:
- cpu_types_pkg additions: mcu_state_t enum (FETCH, DECODE, EXEC, MEM, WB, HALTED, EXC); constants PCSRC_PC4/JR/J/BNE/BEQ/VEC, ALUSRC_RT/SHAMT/SIMM/ZIMM, REGDST_RD/RT/RA.
- Existing opcode_t, funct_t, aluop_t are reused.
- Sub-module mcu_decode: purely combinational IR -> {class, aluop, ALUsrc, RegDst, MemtoReg, illegal}. It is instantiated once, leaving the top with the FSM, IR and watchdog.

Test Plan:
- ADDIU $1,$0,5 (0x24010005), ihit after 2 wait cycles -> iREN 3 cycles, then DECODE, EXEC (ALUsrc=2, aluop=ADD), WB (RegWrite=1, RegDst=1); FETCH re-entered 7 cycles after reset release.
- LW with dhit delayed 4 cycles -> dREN held 5 cycles in MEM, then WB with MemtoReg=1, RegWrite=1 for one cycle.
- BEQ with zero=1 -> PCWrite=1, PCsrc=5 in EXEC. With zero=0 -> PCWrite=0, next state FETCH.
- TIMEOUT_CYC=8, ihit never asserted -> bus_err=1 and halt=1 after 8 FETCH cycles, sticky. Repeat with ihit on cycle 8 -> no error.
- RST asserted mid-MEM on SW -> dWEN falls the same cycle; after release: state=FETCH, iREN=1, halt=0.
- HALT (0xFC000000) -> halt=1 from the cycle after DECODE, held for 20 cycles. With MCU_EXCEPTION_EN, opcode 0x3E -> exc pulse, PCsrc=6, exc_cause=0x3E.
